spi_sclk_gen: RTL
=================

# spi_sclk_gen

Parametrised SPI serial-clock generator, successor to the fixed free-running clock divider in the SPI bus path. It produces a gated SCLK burst of a programmable bit count with runtime divisor and all four CPOL/CPHA modes. It also produces chip-select, single-cycle shift/sample strobes and a done pulse. It sits between the SPI master control FSM (start, nbits, mode) and the shift register, which consumes the strobes, and the pins (sclk, cs_n).

## Interface
- HALF_W, 8: width of half_div; half period up to 2^HALF_W-1 clk cycles
- BITS_W, 6: width of nbits; burst length up to 2^BITS_W-1 bits
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- start  in  1  burst request, honoured only when busy=0
- abort  in  1  synchronous burst cancel
- cpol  in  1  SCLK idle level
- cpha  in  1  0: sample on leading edge, shift on trailing; 1: shift on leading, sample on trailing
- half_div  in  HALF_W  SCLK half period in clk cycles; 0 treated as 1
- nbits  in  BITS_W  bits per burst
- busy  out  1  burst in progress
- cs_n  out  1  chip select, low while busy
- sclk  out  1  serial clock, registered
- shift_stb  out  1  one-cycle pulse: shift register advances
- sample_stb  out  1  one-cycle pulse: capture MISO
- done  out  1  one-cycle pulse at normal burst end

## Operation
- States: IDLE, RUN, TAIL. LEAD is added only with the macro.
- Let H = max(half_div,1) and N = nbits. cpol, cpha, H and N are latched on accepted start. Input changes mid-burst are ignored.
- IDLE:
  - sclk follows cpol, registered, 1-cycle lag. cs_n=1, busy=0.
  - start=1 and N>0: go to RUN, clear the half-period counter, drive cs_n=0 and busy=1.
  - start=1 and N=0: no edges and no cs_n activity; done pulses next cycle.
- RUN:
  - The counter counts 0..H-1. At wrap, sclk toggles and the edge counter increments (edges 1..2N).
  - Odd edges are leading, even edges are trailing.
  - At each edge exactly one strobe pulses, in the same cycle sclk shows the new level. Mapping: cpha=0 gives leading→sample_stb, trailing→shift_stb. cpha=1 gives leading→shift_stb, trailing→sample_stb.
  - After edge 2N, go to TAIL; sclk is back at cpol.
- TAIL: hold H cycles, then return to IDLE with cs_n=1, busy=0 and done=1 for one cycle.
- start while busy: ignored, no queuing.
- abort=1 in any non-IDLE state: IDLE next cycle. sclk=latched cpol, cs_n=1, busy=0, no strobes, no done.
- abort and start together in IDLE: abort wins, start is dropped.
- Edge counter is BITS_W+1 bits wide; no wrap is possible for N ≤ 2^BITS_W-1.
- Reset values: sclk=0, cs_n=1, busy=0, shift_stb=0, sample_stb=0, done=0, state IDLE. After release, sclk takes cpol on the first clock.

## Timing
- start is sampled high at edge T. From T: cs_n=0, busy=1.
- Edge k is registered at T+k·H, k=1..2N.
- done, cs_n=1 and busy=0 occur at T+(2N+1)·H.
- Back-to-back: start is accepted at the cycle after done, giving minimum 1 idle cycle of cs_n=1.
- N=0: done at T+1, and busy stays 0.
- SCLK frequency = f_clk/(2H). The duty cycle is exactly 50% for all H.

## Configuration
- SPI_SCLK_GAP_EN defined:
  - Adds state LEAD of H cycles between start and RUN, giving cs_n setup time.
  - Extends TAIL to 2H cycles.
  - Edge k occurs at T+(k+1)·H. done occurs at T+(2N+3)·H.
  - abort in LEAD behaves as in RUN.
- Undefined: no LEAD, and TAIL is H cycles, as above.

## Structure
- Shared package spi_pkg holds:
  - the state enum (IDLE, LEAD, RUN, TAIL)
  - the CPOL/CPHA mode constants (MODE0..MODE3)
  - default HALF_W/BITS_W constants, reused by the SPI master and shift register
- One sub-module, spi_half_tick, is natural: a loadable half-period counter (clear, H in, tick out at wrap).

## Test plan
- Mode 0 (cpol=0, cpha=0), half_div=2, nbits=8 → 16 sclk edges 2 cycles apart starting T+2. 8 sample_stb on rising, 8 shift_stb on falling. done at T+34, cs_n low T..T+33.
- Mode 3 (cpol=1, cpha=1), half_div=0, nbits=1 → H=1. sclk idles 1, falls at T+1 with shift_stb, rises at T+2 with sample_stb. done at T+3.
- nbits=0 with start → no sclk/strobe/cs_n activity, busy stays 0, done at T+1.
- half_div=3, nbits=4, abort at T+7 → IDLE at T+8, sclk=cpol, cs_n=1, no done. Exactly 2 edges seen.
- start pulsed mid-burst and cpol/half_div changed mid-burst → no effect on the running burst. Back-to-back start the cycle after done → accepted.
- With SPI_SCLK_GAP_EN, half_div=2, nbits=2 → first edge at T+4, done at T+14.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions: burst-sequencer states, CPOL/CPHA mode encodings
// and default field widths used across the SPI master, clock generator and
// shift register.
package spi_pkg;

  // LEAD is only entered when SPI_SCLK_GAP_EN is defined.
  typedef enum logic [1:0] {
    StIdle,
    StLead,
    StRun,
    StTail
  } spi_state_e;

  // Mode encodings as {cpol, cpha}.
  localparam logic [1:0] Mode0 = 2'b00;
  localparam logic [1:0] Mode1 = 2'b01;
  localparam logic [1:0] Mode2 = 2'b10;
  localparam logic [1:0] Mode3 = 2'b11;

  localparam int unsigned DefHalfW = 8;
  localparam int unsigned DefBitsW = 6;

  // Odd (leading) edges sample when cpha=0; even (trailing) edges sample when cpha=1.
  function automatic logic is_sample_edge(logic cpha, logic leading);
    return leading ^ cpha;
  endfunction

endpackage

// File: rtl/spi_half_tick.sv
// Half-period counter for the SPI clock generator. Held at zero while
// disabled, counts 0..half_i-1 while enabled and flags the wrap cycle.
// half_i must be non-zero.
module spi_half_tick #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [Width-1:0] half_i,
  output logic             tick_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == (half_i - Width'(1)));

  // Restart from zero when disabled or on wrap.
  always_comb begin
    cnt_d = cnt_q + Width'(1);
    if (!en_i || tick_o) begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_sclk_gen.sv
// SPI serial-clock generator: emits a gated SCLK burst of nbits bits in any
// CPOL/CPHA mode with a runtime half-period, plus cs_n, shift/sample strobes
// and a done pulse. All outputs are registered.
// Optional macro SPI_SCLK_GAP_EN adds an H-cycle LEAD state before the first
// edge and stretches TAIL to 2H cycles.
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int unsigned HALF_W = DefHalfW,
  parameter int unsigned BITS_W = DefBitsW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [HALF_W-1:0] half_div,
  input  logic [BITS_W-1:0] nbits,
  output logic              busy,
  output logic              cs_n,
  output logic              sclk,
  output logic              shift_stb,
  output logic              sample_stb,
  output logic              done
);

  spi_state_e        state_q, state_d;
  logic              cpol_q, cpol_d;
  logic              cpha_q, cpha_d;
  logic [HALF_W-1:0] half_q, half_d;
  logic [BITS_W-1:0] nbits_q, nbits_d;
  logic [BITS_W:0]   edge_q, edge_d;
  logic              sclk_q, sclk_d;
  logic              cs_n_q, cs_n_d;
  logic              busy_q, busy_d;
  logic              shift_q, shift_d;
  logic              sample_q, sample_d;
  logic              done_q, done_d;
  // A zero-length burst still owes a done pulse on the following cycle.
  logic              zero_q, zero_d;
`ifdef SPI_SCLK_GAP_EN
  // Set once the first of the two TAIL half periods has elapsed.
  logic              tail2_q, tail2_d;
`endif

  logic            tick;
  logic            running;
  logic [BITS_W:0] last_edge;

  assign running   = (state_q != StIdle);
  assign last_edge = {nbits_q, 1'b0};

  spi_half_tick #(
    .Width (HALF_W)
  ) u_half_tick (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .en_i   (running),
    .half_i (half_q),
    .tick_o (tick)
  );

  // Next-state and registered-output logic for the burst sequencer.
  always_comb begin
    state_d  = state_q;
    cpol_d   = cpol_q;
    cpha_d   = cpha_q;
    half_d   = half_q;
    nbits_d  = nbits_q;
    edge_d   = edge_q;
    sclk_d   = sclk_q;
    cs_n_d   = cs_n_q;
    busy_d   = busy_q;
    shift_d  = 1'b0;
    sample_d = 1'b0;
    done_d   = 1'b0;
    zero_d   = 1'b0;
`ifdef SPI_SCLK_GAP_EN
    tail2_d  = tail2_q;
`endif

    case (state_q)
      StIdle: begin
        sclk_d = cpol;
        cs_n_d = 1'b1;
        busy_d = 1'b0;
        done_d = zero_q;
        if (start && !abort) begin
          cpol_d  = cpol;
          cpha_d  = cpha;
          half_d  = (half_div == '0) ? HALF_W'(1) : half_div;
          nbits_d = nbits;
          edge_d  = '0;
          if (nbits != '0) begin
            cs_n_d  = 1'b0;
            busy_d  = 1'b1;
`ifdef SPI_SCLK_GAP_EN
            state_d = StLead;
`else
            state_d = StRun;
`endif
          end else begin
            zero_d = 1'b1;
          end
        end
      end

`ifdef SPI_SCLK_GAP_EN
      StLead: begin
        if (tick) begin
          state_d = StRun;
        end
      end
`endif

      StRun: begin
        if (tick) begin
          edge_d = edge_q + (BITS_W+1)'(1);
          sclk_d = ~sclk_q;
          if (is_sample_edge(cpha_q, edge_d[0])) begin
            sample_d = 1'b1;
          end else begin
            shift_d = 1'b1;
          end
          if (edge_d == last_edge) begin
            state_d = StTail;
`ifdef SPI_SCLK_GAP_EN
            tail2_d = 1'b0;
`endif
          end
        end
      end

      StTail: begin
        if (tick) begin
`ifdef SPI_SCLK_GAP_EN
          if (!tail2_q) begin
            tail2_d = 1'b1;
          end else begin
            state_d = StIdle;
            cs_n_d  = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
`else
          state_d = StIdle;
          cs_n_d  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
`endif
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort overrides everything once a burst is under way.
    if (running && abort) begin
      state_d  = StIdle;
      sclk_d   = cpol_q;
      cs_n_d   = 1'b1;
      busy_d   = 1'b0;
      shift_d  = 1'b0;
      sample_d = 1'b0;
      done_d   = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      half_q   <= HALF_W'(1);
      nbits_q  <= '0;
      edge_q   <= '0;
      sclk_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      busy_q   <= 1'b0;
      shift_q  <= 1'b0;
      sample_q <= 1'b0;
      done_q   <= 1'b0;
      zero_q   <= 1'b0;
`ifdef SPI_SCLK_GAP_EN
      tail2_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cpol_q   <= cpol_d;
      cpha_q   <= cpha_d;
      half_q   <= half_d;
      nbits_q  <= nbits_d;
      edge_q   <= edge_d;
      sclk_q   <= sclk_d;
      cs_n_q   <= cs_n_d;
      busy_q   <= busy_d;
      shift_q  <= shift_d;
      sample_q <= sample_d;
      done_q   <= done_d;
      zero_q   <= zero_d;
`ifdef SPI_SCLK_GAP_EN
      tail2_q  <= tail2_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign cs_n       = cs_n_q;
  assign sclk       = sclk_q;
  assign shift_stb  = shift_q;
  assign sample_stb = sample_q;
  assign done       = done_q;

endmodule
